// File: rtl/decode_general_register_pkg.sv
// rtl/decode_general_register_pkg.sv - shared register-index constants, mode enum and select type
package decode_general_register_pkg;

  localparam logic [2:0] REG_0 = 3'd0;
  localparam logic [2:0] REG_1 = 3'd1;
  localparam logic [2:0] REG_2 = 3'd2;
  localparam logic [2:0] REG_3 = 3'd3;
  localparam logic [2:0] REG_4 = 3'd4;
  localparam logic [2:0] REG_5 = 3'd5;
  localparam logic [2:0] REG_6 = 3'd6;
  localparam logic [2:0] REG_7 = 3'd7;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_8    = 2'd1,
    MODE_16   = 2'd2,
    MODE_32   = 2'd3
  } mode_e;

  typedef logic [7:0] sel_t;

  function automatic sel_t reg_onehot(input logic [2:0] idx);
    return sel_t'(8'd1 << idx);
  endfunction

endpackage

// File: rtl/decode_general_register_comb.sv
// rtl/decode_general_register_comb.sv - combinational operand-size and reg-field decode
module decode_general_register_comb
  import decode_general_register_pkg::*;
(
  input  logic [2:0] instruction_reg_i,
  input  logic       bit_width_16_i,
  input  logic       bit_width_32_i,
  input  logic       w_is_present_i,
  input  logic       w_i,
  output mode_e      mode_o,
  output sel_t       sel8_o,
  output sel_t       sel16_o,
  output sel_t       sel32_o
);

  mode_e mode;
  sel_t  sel;

  // Byte mode outranks the width inputs; equal widths decode to nothing.
  always_comb begin
    mode = MODE_NONE;
    if (w_is_present_i && !w_i) begin
      mode = MODE_8;
    end else if (bit_width_16_i && !bit_width_32_i) begin
      mode = MODE_16;
    end else if (bit_width_32_i && !bit_width_16_i) begin
      mode = MODE_32;
    end
  end

  always_comb begin
    sel     = reg_onehot(instruction_reg_i);
    mode_o  = mode;
    sel8_o  = (mode == MODE_8)  ? sel : '0;
    sel16_o = (mode == MODE_16) ? sel : '0;
    sel32_o = (mode == MODE_32) ? sel : '0;
  end

endmodule

// File: rtl/decode_general_register.sv
// rtl/decode_general_register.sv - registered general-register select decode
// Optional width_conflict output compiled in by DECODE_GENERAL_REGISTER_CHECK_EN.
module decode_general_register
  import decode_general_register_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] instruction_reg,
  input  logic       bit_width_16,
  input  logic       bit_width_32,
  input  logic       w_is_present,
  input  logic       w,
  output logic       AL,
  output logic       CL,
  output logic       DL,
  output logic       BL,
  output logic       AH,
  output logic       CH,
  output logic       DH,
  output logic       BH,
  output logic       AX,
  output logic       CX,
  output logic       DX,
  output logic       BX,
  output logic       SP,
  output logic       BP,
  output logic       SI,
  output logic       DI,
  output logic       EAX,
  output logic       ECX,
  output logic       EDX,
  output logic       EBX,
  output logic       ESP,
  output logic       EBP,
  output logic       ESI,
  output logic       EDI
`ifdef DECODE_GENERAL_REGISTER_CHECK_EN
  ,
  output logic       width_conflict
`endif
);

  mode_e mode;
  sel_t  sel8, sel16, sel32;
  sel_t  sel8_d, sel16_d, sel32_d;
  sel_t  sel8_q, sel16_q, sel32_q;

  decode_general_register_comb u_comb (
    .instruction_reg_i (instruction_reg),
    .bit_width_16_i    (bit_width_16),
    .bit_width_32_i    (bit_width_32),
    .w_is_present_i    (w_is_present),
    .w_i               (w),
    .mode_o            (mode),
    .sel8_o            (sel8),
    .sel16_o           (sel16),
    .sel32_o           (sel32)
  );

  // Only the group named by the mode may load, so the register bank stays one-hot-or-zero.
  always_comb begin
    sel8_d  = '0;
    sel16_d = '0;
    sel32_d = '0;
    case (mode)
      MODE_8:  sel8_d  = sel8;
      MODE_16: sel16_d = sel16;
      MODE_32: sel32_d = sel32;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel8_q  <= '0;
      sel16_q <= '0;
      sel32_q <= '0;
    end else begin
      sel8_q  <= sel8_d;
      sel16_q <= sel16_d;
      sel32_q <= sel32_d;
    end
  end

`ifdef DECODE_GENERAL_REGISTER_CHECK_EN
  logic conflict_d, conflict_q;

  always_comb begin
    conflict_d = bit_width_16 && bit_width_32 && (mode != MODE_8);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign width_conflict = conflict_q;
`endif

  assign AL  = sel8_q[REG_0];
  assign CL  = sel8_q[REG_1];
  assign DL  = sel8_q[REG_2];
  assign BL  = sel8_q[REG_3];
  assign AH  = sel8_q[REG_4];
  assign CH  = sel8_q[REG_5];
  assign DH  = sel8_q[REG_6];
  assign BH  = sel8_q[REG_7];

  assign AX  = sel16_q[REG_0];
  assign CX  = sel16_q[REG_1];
  assign DX  = sel16_q[REG_2];
  assign BX  = sel16_q[REG_3];
  assign SP  = sel16_q[REG_4];
  assign BP  = sel16_q[REG_5];
  assign SI  = sel16_q[REG_6];
  assign DI  = sel16_q[REG_7];

  assign EAX = sel32_q[REG_0];
  assign ECX = sel32_q[REG_1];
  assign EDX = sel32_q[REG_2];
  assign EBX = sel32_q[REG_3];
  assign ESP = sel32_q[REG_4];
  assign EBP = sel32_q[REG_5];
  assign ESI = sel32_q[REG_6];
  assign EDI = sel32_q[REG_7];

endmodule

// File: tb/tb_decode_general_register.sv
// tb/tb_decode_general_register.sv - directed self-checking bench for decode_general_register
module tb_decode_general_register;

  logic       clock;
  logic       reset;
  logic [2:0] instruction_reg;
  logic       bit_width_16, bit_width_32, w_is_present, w;
  logic AL, CL, DL, BL, AH, CH, DH, BH;
  logic AX, CX, DX, BX, SP, BP, SI, DI;
  logic EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI;
  logic width_conflict;
  logic [23:0] obs;

  int tests = 0;
  int fails = 0;

  decode_general_register dut (
    .clock           (clock),
    .reset           (reset),
    .instruction_reg (instruction_reg),
    .bit_width_16    (bit_width_16),
    .bit_width_32    (bit_width_32),
    .w_is_present    (w_is_present),
    .w               (w),
    .AL (AL), .CL (CL), .DL (DL), .BL (BL), .AH (AH), .CH (CH), .DH (DH), .BH (BH),
    .AX (AX), .CX (CX), .DX (DX), .BX (BX), .SP (SP), .BP (BP), .SI (SI), .DI (DI),
    .EAX(EAX), .ECX(ECX), .EDX(EDX), .EBX(EBX), .ESP(ESP), .EBP(EBP), .ESI(ESI), .EDI(EDI)
`ifdef DECODE_GENERAL_REGISTER_CHECK_EN
    , .width_conflict (width_conflict)
`endif
  );

`ifndef DECODE_GENERAL_REGISTER_CHECK_EN
  assign width_conflict = 1'b0;
`endif

  // Bit n of each byte lane is reg n: [7:0] AL..BH, [15:8] AX..DI, [23:16] EAX..EDI.
  assign obs = {EDI, ESI, EBP, ESP, EBX, EDX, ECX, EAX,
                DI, SI, BP, SP, BX, DX, CX, AX,
                BH, DH, CH, AH, BL, DL, CL, AL};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic [2:0] r, input logic b16, input logic b32,
                       input logic wp, input logic wv);
    @(negedge clock);
    instruction_reg = r;
    bit_width_16    = b16;
    bit_width_32    = b32;
    w_is_present    = wp;
    w               = wv;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instruction_reg = 3'd7; bit_width_16 = 1'b0; bit_width_32 = 1'b1;
    w_is_present = 1'b0; w = 1'b0;
    #1;
    tests++;
    if (obs !== 24'h0) begin
      fails++; $display("FAIL reset_selects got=%h want=%h", obs, 24'h0);
    end
    tests++;
    if (width_conflict !== 1'b0) begin
      fails++; $display("FAIL reset_conflict got=%b want=0", width_conflict);
    end
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (obs !== 24'h0) begin
      fails++; $display("FAIL reset_held got=%h want=%h", obs, 24'h0);
    end
  endtask

  task automatic test_reset_release;
    @(negedge clock);
    instruction_reg = 3'd3; bit_width_16 = 1'b1; bit_width_32 = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    tests++;
    if (obs !== 24'h000800) begin
      fails++; $display("FAIL release_first_edge got=%h want=%h", obs, 24'h000800);
    end
  endtask

  task automatic test_word16;
    logic [23:0] exp;
    for (int n = 0; n < 8; n++) begin
      drive(3'(n), 1'b1, 1'b0, 1'b0, 1'(n % 2));
      exp = 24'h000100 << n;
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL word16 reg=%0d got=%h want=%h", n, obs, exp);
      end
    end
  endtask

  task automatic test_dword32;
    logic [23:0] exp;
    for (int n = 0; n < 8; n++) begin
      drive(3'(n), 1'b0, 1'b1, 1'b1, 1'b1);
      exp = 24'h010000 << n;
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL dword32 reg=%0d got=%h want=%h", n, obs, exp);
      end
    end
    drive(3'd5, 1'b0, 1'b1, 1'b1, 1'b1);
    tests++;
    if (obs !== 24'h200000 || EBP !== 1'b1) begin
      fails++; $display("FAIL dword32_ebp got=%h want=%h", obs, 24'h200000);
    end
  endtask

  task automatic test_byte;
    logic [23:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      for (int n = 0; n < 8; n++) begin
        drive(3'(n), 1'(pass == 0), 1'(pass == 1), 1'b1, 1'b0);
        exp = 24'h000001 << n;
        tests++;
        if (obs !== exp) begin
          fails++; $display("FAIL byte pass=%0d reg=%0d got=%h want=%h", pass, n, obs, exp);
        end
      end
    end
    drive(3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    tests++;
    if (obs !== 24'h000010 || AH !== 1'b1) begin
      fails++; $display("FAIL byte_ah got=%h want=%h", obs, 24'h000010);
    end
  endtask

  task automatic test_no_width;
    for (int n = 0; n < 8; n++) begin
      drive(3'(n), 1'b0, 1'b0, 1'b0, 1'b1);
      tests++;
      if (obs !== 24'h0 || width_conflict !== 1'b0) begin
        fails++; $display("FAIL none reg=%0d got=%h/%b want=0/0", n, obs, width_conflict);
      end
    end
    drive(3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (obs !== 24'h0) begin
      fails++; $display("FAIL both_widths got=%h want=%h", obs, 24'h0);
    end
`ifdef DECODE_GENERAL_REGISTER_CHECK_EN
    tests++;
    if (width_conflict !== 1'b1) begin
      fails++; $display("FAIL conflict_set got=%b want=1", width_conflict);
    end
    drive(3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tests++;
    if (width_conflict !== 1'b0 || obs !== 24'h000004) begin
      fails++; $display("FAIL conflict_byte got=%b/%h want=0/%h", width_conflict, obs, 24'h000004);
    end
`endif
  endtask

  task automatic test_hold;
    drive(3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    instruction_reg = 3'd6; bit_width_16 = 1'b0; bit_width_32 = 1'b1;
    #2;
    tests++;
    if (obs !== 24'h000200) begin
      fails++; $display("FAIL hold_between_edges got=%h want=%h", obs, 24'h000200);
    end
    @(posedge clock);
    #1;
    tests++;
    if (obs !== 24'h400000) begin
      fails++; $display("FAIL hold_next_edge got=%h want=%h", obs, 24'h400000);
    end
  endtask

  task automatic test_async_reset;
    drive(3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (EDI !== 1'b1) begin
      fails++; $display("FAIL edi_set got=%b want=1", EDI);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (EDI !== 1'b0 || obs !== 24'h0) begin
      fails++; $display("FAIL async_clear got=%h want=%h", obs, 24'h0);
    end
    @(posedge clock);
    #1;
    tests++;
    if (obs !== 24'h0) begin
      fails++; $display("FAIL reset_hold_edge got=%h want=%h", obs, 24'h0);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_exhaustive;
    logic [23:0] exp;
    logic        exp_conf;
    logic [6:0]  v;
    for (int i = 0; i < 128; i++) begin
      v = 7'(i);
      drive(v[6:4], v[3], v[2], v[1], v[0]);
      exp = 24'h0;
      exp_conf = 1'b0;
      if (v[1] && !v[0]) begin
        exp[v[6:4]] = 1'b1;
      end else if (v[3] && !v[2]) begin
        exp[8 + int'(v[6:4])] = 1'b1;
      end else if (v[2] && !v[3]) begin
        exp[16 + int'(v[6:4])] = 1'b1;
      end else if (v[2] && v[3]) begin
        exp_conf = 1'b1;
      end
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL exhaustive vec=%0d got=%h want=%h", i, obs, exp);
      end
      tests++;
      if (!$onehot0(obs)) begin
        fails++; $display("FAIL onehot vec=%0d got=%h want=onehot0", i, obs);
      end
`ifdef DECODE_GENERAL_REGISTER_CHECK_EN
      tests++;
      if (width_conflict !== exp_conf) begin
        fails++; $display("FAIL conflict vec=%0d got=%b want=%b", i, width_conflict, exp_conf);
      end
`else
      if (exp_conf) exp_conf = 1'b0;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_word16();
    test_dword32();
    test_byte();
    test_no_width();
    test_hold();
    test_async_reset();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_general_register.md
DECODE_GENERAL_REGISTER -- requirements
Module: decode_general_register

Interface
REQ-001 clock  input  1  single system clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 instruction_reg  input  3  reg field of the instruction (0..7).
REQ-004 bit_width_16  input  1  operand size is 16-bit.
REQ-005 bit_width_32  input  1  operand size is 32-bit.
REQ-006 w_is_present  input  1  opcode carries a w bit.
REQ-007 w  input  1  w bit: 0 = byte operand, 1 = full-size operand.
REQ-008 AL CL DL BL AH CH DH BH  output  1 each  8-bit register selects for reg 0..7, in that order.
REQ-009 AX CX DX BX SP BP SI DI  output  1 each  16-bit register selects for reg 0..7.
REQ-010 EAX ECX EDX EBX ESP EBP ESI EDI  output  1 each  32-bit register selects for reg 0..7.
REQ-011 width_conflict  output  1  present only with DECODE_GENERAL_REGISTER_CHECK_EN (see REQ-027).
REQ-012 No parameters.

Function
REQ-013 Byte mode SHALL be selected when w_is_present=1 and w=0, regardless of bit_width_16/bit_width_32.
REQ-014 In byte mode, instruction_reg value n SHALL assert the n-th signal of the AL..BH group (0=AL, 4=AH, 7=BH).
REQ-015 When w_is_present=0, w SHALL be ignored.
REQ-016 When not in byte mode and bit_width_16=1, bit_width_32=0: value n SHALL assert the n-th signal of the AX..DI group.
REQ-017 When not in byte mode and bit_width_32=1, bit_width_16=0: value n SHALL assert the n-th signal of the EAX..EDI group.
REQ-018 When not in byte mode and bit_width_16 equals bit_width_32 (both 0 or both 1): all 24 selects SHALL be 0.
REQ-019 At most one of the 24 select outputs SHALL be 1 at any time.
REQ-020 All outputs SHALL be registered: inputs are sampled on a rising clock edge, and the decoded selects are valid after that edge (latency 1 cycle).
REQ-021 Outputs SHALL hold their value until the next rising edge; no input-to-output combinational path.
REQ-022 Every input combination SHALL produce a defined output; no X propagation from legal 0/1 inputs.

Reset
REQ-023 While reset=1, all 24 selects (and width_conflict) SHALL be 0, asynchronously and independent of clock.
REQ-024 On reset deassertion, the first rising edge SHALL load the decode of the current inputs.
REQ-025 Reset asserted mid-operation SHALL clear outputs immediately; previous decode is not retained.

Configuration
REQ-026 Macro DECODE_GENERAL_REGISTER_CHECK_EN SHALL compile in the width_conflict port and its logic.
REQ-027 With the macro: width_conflict is registered, reset to 0, and is 1 one cycle after a sample where bit_width_16=1 and bit_width_32=1 and the operand is not byte mode; otherwise 0.
REQ-028 Without the macro: the port and logic SHALL be absent; REQ-013..REQ-025 are unchanged.

Structure
REQ-029 Shared package decode_general_register_pkg SHALL hold the 3-bit register-index constants (REG_0..REG_7), a mode enum (MODE_NONE, MODE_8, MODE_16, MODE_32), and a typedef for an 8-bit one-hot select vector.
REQ-030 Combinational decode SHALL live in sub-module decode_general_register_comb (inputs -> mode and three 8-bit one-hot vectors); the top module adds registers, reset, and the optional check.

Verification
REQ-031 w_is_present=0, bit_width_16=1, reg 0..7 -> one cycle later AX, CX, DX, BX, SP, BP, SI, DI each high in turn; all others 0.
REQ-032 w_is_present=1, w=1, bit_width_32=1, reg 0..7 -> EAX..EDI in turn; reg=5 -> EBP only.
REQ-033 w_is_present=1, w=0, bit_width_16=1 and then bit_width_32=1, reg 0..7 -> AL, CL, DL, BL, AH, CH, DH, BH in turn in both cases; reg=4 -> AH only.
REQ-034 w_is_present=0, bit_width_16=0, bit_width_32=0, any reg -> all selects 0; both widths=1 -> all 0, and width_conflict=1 with the macro.
REQ-035 Assert reset between clock edges while EDI=1 -> EDI drops to 0 before the next edge; it stays 0 while reset=1.
REQ-036 All 128 input combinations -> outputs match the REQ-013..REQ-018 model one cycle later, with one-hot-or-zero checked every cycle.
